// File: rtl/clahe_cdf_engine.sv
// CLAHE CDF engine: per tile, clips the 256-bin histogram, redistributes the excess,
// and overwrites each bin in place with an 8-bit normalised CDF LUT entry.
module clahe_cdf_engine #(
    parameter int unsigned TILE_NUM    = 16,
    parameter int unsigned BINS        = 256,
    parameter int unsigned SCALE_MUL   = 74275,
    parameter int unsigned SCALE_SHIFT = 24
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] clip_limit,
    output logic        busy,
    output logic        done,
    output logic [3:0]  cdf_tile_idx,
    output logic [7:0]  cdf_addr,
    output logic        cdf_rd_en,
    input  logic [15:0] cdf_rd_data,
    output logic        cdf_wr_en,
    output logic [7:0]  cdf_wr_data
);

    localparam logic [7:0]  LAST_BIN    = 8'(BINS - 1);
    localparam logic [3:0]  LAST_TILE   = 4'(TILE_NUM - 1);
    localparam logic [47:0] SCALE_MUL_W = 48'(SCALE_MUL);

    typedef enum logic [2:0] {
        IDLE, P1_RD, P1_TAIL, CALC, P2_RD, P2_WR, NEXT, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  tile_q, tile_d;
    logic [7:0]  addr_q, addr_d;
    logic        rd_en_q, rd_en_d;
    logic        wr_en_q, wr_en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] clip_q, clip_d;
    logic [23:0] excess_q, excess_d;
    logic [15:0] inc_q, inc_d;
    logic [23:0] cdf_sum_q, cdf_sum_d;

    logic [15:0] over, hmin;
    logic [24:0] exc_sum, cdf_ext;
    logic [23:0] excess_new, cdf_sum_new;
    logic [16:0] c_val;
    logic [47:0] prod, scaled;
    logic [7:0]  lut_val;

    // Datapath: cdf_rd_data is the bin read in the previous cycle.
    always_comb begin
        over        = (cdf_rd_data > clip_q) ? (cdf_rd_data - clip_q) : 16'd0;
        exc_sum     = {1'b0, excess_q} + {9'd0, over};
        excess_new  = exc_sum[24] ? 24'hFF_FFFF : exc_sum[23:0];
        hmin        = (cdf_rd_data < clip_q) ? cdf_rd_data : clip_q;
        c_val       = {1'b0, hmin} + {1'b0, inc_q};
        cdf_ext     = {1'b0, cdf_sum_q} + {8'd0, c_val};
        cdf_sum_new = cdf_ext[24] ? 24'hFF_FFFF : cdf_ext[23:0];
        prod        = {24'd0, cdf_sum_new} * SCALE_MUL_W;
        scaled      = prod >> SCALE_SHIFT;
        lut_val     = (scaled > 48'd255) ? 8'hFF : scaled[7:0];
    end

    always_comb begin
        state_d   = state_q;
        tile_d    = tile_q;
        addr_d    = addr_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        clip_d    = clip_q;
        excess_d  = excess_q;
        inc_d     = inc_q;
        cdf_sum_d = cdf_sum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = P1_RD;
                    tile_d   = 4'd0;
                    addr_d   = 8'd0;
                    rd_en_d  = 1'b1;
                    busy_d   = 1'b1;
                    clip_d   = (clip_limit == 16'd0) ? 16'hFFFF : clip_limit;
                    excess_d = 24'd0;
                end
            end
            P1_RD: begin
                // The first read cycle has no returned data yet.
                if (addr_q != 8'd0) excess_d = excess_new;
                if (addr_q == LAST_BIN) begin
                    state_d = P1_TAIL;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    rd_en_d = 1'b1;
                end
            end
            P1_TAIL: begin
                excess_d = excess_new;
                addr_d   = 8'd0;
                state_d  = CALC;
            end
            CALC: begin
                inc_d     = excess_q[23:8];
                cdf_sum_d = 24'd0;
                addr_d    = 8'd0;
                rd_en_d   = 1'b1;
                state_d   = P2_RD;
            end
            P2_RD: begin
                wr_en_d = 1'b1;
                state_d = P2_WR;
            end
            P2_WR: begin
                cdf_sum_d = cdf_sum_new;
                if (addr_q == LAST_BIN) begin
                    state_d = NEXT;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    rd_en_d = 1'b1;
                    state_d = P2_RD;
                end
            end
            NEXT: begin
                excess_d = 24'd0;
                if (tile_q == LAST_TILE) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    tile_d  = tile_q + 4'd1;
                    addr_d  = 8'd0;
                    rd_en_d = 1'b1;
                    state_d = P1_RD;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tile_q    <= 4'd0;
            addr_q    <= 8'd0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clip_q    <= 16'd0;
            excess_q  <= 24'd0;
            inc_q     <= 16'd0;
            cdf_sum_q <= 24'd0;
        end else begin
            state_q   <= state_d;
            tile_q    <= tile_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            clip_q    <= clip_d;
            excess_q  <= excess_d;
            inc_q     <= inc_d;
            cdf_sum_q <= cdf_sum_d;
        end
    end

    // Write data must come straight from the read return: the shared address
    // leaves no spare cycle to register it before the write.
    assign cdf_wr_data  = wr_en_q ? lut_val : 8'd0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cdf_tile_idx = tile_q;
    assign cdf_addr     = addr_q;
    assign cdf_rd_en    = rd_en_q;
    assign cdf_wr_en    = wr_en_q;

endmodule

// File: doc/clahe_cdf_engine.md
Name: clahe_cdf_engine

Overview:
- Initiator on the CDF port of the 16-tile ping-pong histogram RAM. Runs in vertical blanking after histogram statistics complete.
- For each of 16 tiles it reads the 256-bin histogram, clips it, and redistributes the excess uniformly.
- It then computes the cumulative sum and overwrites each bin in place with an 8-bit normalised CDF LUT entry, which the mapping stage reads in the next frame.

Parameters:
TILE_NUM, 16, tiles processed per run (tile_idx 0..TILE_NUM-1)
BINS, 256, bins per tile
SCALE_MUL, 74275, ceil(255*2^SCALE_SHIFT/tile_pixels); default is for 320x180 = 57600 pixels
SCALE_SHIFT, 24, right shift applied after the scale multiply

Ports:
pclk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a 16-tile run
clip_limit  in  16  clip threshold per bin; 0 = clipping disabled; sampled on accepted start
busy  out  1  high while a run is in progress
done  out  1  one-cycle pulse at end of run
cdf_tile_idx  out  4  tile being processed
cdf_addr  out  8  bin address, shared by read and write
cdf_rd_en  out  1  read request; data valid on cdf_rd_data the next cycle
cdf_rd_data  in  16  histogram count (registered RAM read, 1-cycle latency)
cdf_wr_en  out  1  write LUT entry at cdf_addr
cdf_wr_data  out  8  LUT value

Behaviour:
- Reset values: busy=0, done=0, cdf_tile_idx=0, cdf_addr=0, cdf_rd_en=0, cdf_wr_en=0, cdf_wr_data=0. All internal accumulators are 0 and the FSM is in IDLE.
- Reset asserted mid-run aborts immediately with no further writes. A partially written tile is left as is.
- start is accepted only in IDLE. start while busy is ignored (no restart, no queuing).
- On acceptance, clip_limit is latched as clip_r; clip_limit=0 latches 0xFFFF.
- FSM:
  - IDLE: on start go to P1_RD; tile=0, addr=0.
  - P1_RD (256 cycles): cdf_rd_en=1, addr=k for k=0..255.
  - P1_TAIL (1 cycle): no request; captures bin 255.
    - Each cycle after a read, data for bin k-1 is consumed: excess += max(h-clip_r, 0).
    - excess is 24 bits and saturates.
  - CALC (1 cycle): inc = excess>>8, saturated to 16 bits; cdf_sum=0; addr=0.
  - P2_RD (1 cycle/bin): cdf_rd_en=1, addr=k.
  - P2_WR (1 cycle/bin): addr=k held, cdf_wr_en=1.
    - c = min(h, clip_r) + inc, 17 bits.
    - cdf_sum += c, 24 bits, saturating.
    - cdf_wr_data = min(255, (cdf_sum_new*SCALE_MUL)>>SCALE_SHIFT), where cdf_sum_new includes bin k.
    - Then go to P2_RD with k+1, or to NEXT after k=255.
  - NEXT (1 cycle): clear excess; if tile=15 go to DONE, else tile+1 and go to P1_RD.
  - DONE (1 cycle): done=1, busy=0; return to IDLE.
- The 2-cycle P2 bin cadence is mandatory because read and write share cdf_addr.
- cdf_rd_en and cdf_wr_en are never high in the same cycle.
- Redistribution remainder (excess mod 256) is discarded.
- Timing:
  - Per tile: 256 + 1 + 1 + 512 + 1 = 771 cycles.
  - busy rises the cycle after start and stays high 16*771 = 12336 cycles.
  - done pulses in the cycle busy returns low.
  - A new start is accepted the cycle after done.
- cdf_tile_idx changes only in NEXT; it is stable throughout each tile.
- Precondition (not checked): no histogram port activity during a run; ping_pong_flag static during a run.

Test Plan:
- Flat histogram, 225 per bin in all tiles, clip_limit=0 -> every tile LUT[0]=0, LUT[127]=127, LUT[255]=255; done after 12336 busy cycles.
- Tile 3 has all 57600 counts in bin 100, clip_limit=0 -> tile 3 LUT[0..99]=0, LUT[100..255]=255; other tiles (all zero) LUT=0.
- Same spike, clip_limit=1000 -> excess=56600, inc=221; LUT[99]=97, LUT[100]=103, LUT[255]=254.
- Protocol monitor across a full run:
  - no cycle has cdf_rd_en and cdf_wr_en both high;
  - each P2 write address equals the preceding read address;
  - exactly 4096 writes and 8192 reads.
- start pulsed again at busy cycle 500 -> ignored: busy, done timing and LUT contents unchanged.
- rst_n low in tile 5 P2 -> all outputs 0 next edge. After release, a new start yields correct LUTs for all 16 tiles.
